apu_master_rob: RTL and testbench
=================================

Name: apu_master_rob

Overview:
- Initiator (master) end of the APU req/gnt + rvalid/rID protocol.
- Sits between a core-side issue port and a shared FP unit wrapper.
- Tags each accepted operation with a reorder-buffer slot index, drives it onto the APU request channel, and absorbs out-of-order responses keyed by rID.
- Returns results to the core strictly in issue order.

Parameters:
- ID_WIDTH, 9, APU tag width; must be >= log2(DEPTH).
- NB_ARGS, 2, operands per request.
- OPCODE_WIDTH, 6, APU op field width.
- DATA_WIDTH, 32, operand/result width.
- FLAGS_IN_WIDTH, 15, request flags width.
- FLAGS_OUT_WIDTH, 5, response status width.
- DEPTH, 4, outstanding operations (ROB entries); power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- core_valid_i  in  1  core offers request
- core_ready_o  out  1  request accepted this cycle when valid&ready
- core_operands_i  in  NB_ARGS*DATA_WIDTH  operands
- core_op_i  in  OPCODE_WIDTH  opcode
- core_flags_i  in  FLAGS_IN_WIDTH  format/rounding flags
- core_rvalid_o  out  1  in-order result available
- core_rready_i  in  1  core takes result
- core_rdata_o  out  DATA_WIDTH  result
- core_rflags_o  out  FLAGS_OUT_WIDTH  status flags
- apu_req_o  out  1  APU request
- apu_gnt_i  in  1  APU grant
- apu_ID_o  out  ID_WIDTH  tag, zero-extended slot index
- apu_operands_o  out  NB_ARGS*DATA_WIDTH  registered operands
- apu_op_o  out  OPCODE_WIDTH  registered opcode
- apu_flags_o  out  FLAGS_IN_WIDTH  registered flags
- apu_rready_o  out  1  constant 1; slot is pre-reserved
- apu_rvalid_i  in  1  response valid
- apu_rdata_i  in  DATA_WIDTH  response data
- apu_rflags_i  in  FLAGS_OUT_WIDTH  response status
- apu_rID_i  in  ID_WIDTH  response tag
- tag_err_o  out  1  sticky bad-tag flag (see Optional Feature)
- busy_o  out  1  count != 0 or request pending

Behaviour:
- Clocking and reset: one clock domain. In every cycle with rst=1, all state clears: pending=0, wr_ptr=rd_ptr=0, count=0, all done bits cleared, tag_err=0.
- Output reset values:
  - apu_req_o=0, core_rvalid_o=0, busy_o=0, tag_err_o=0.
  - apu_ID_o, apu_operands_o, apu_op_o, apu_flags_o, core_rdata_o, core_rflags_o = 0.
  - core_ready_o=1 and apu_rready_o=1.
- Request register:
  - apu_req_o = pending.
  - core_ready_o = (count < DEPTH) && (!pending || apu_gnt_i).
  - On core accept: payload and apu_ID_o <= wr_ptr are registered, pending <= 1, wr_ptr++ mod DEPTH, slot reserved.
  - Latency: accept in cycle N gives apu_req_o in cycle N+1.
  - apu_req_o=1 and payload are held stable until apu_gnt_i.
  - Grant and new accept in the same cycle leave pending=1 with the new payload (back-to-back issue, one op per cycle).
  - Grant without accept sets pending <= 0.
- ROB: entry = {done, data, flags}.
  - On apu_rvalid_i, entry[apu_rID_i[log2(DEPTH)-1:0]] gets data/flags and done <= 1.
  - Head handshake: core_rvalid_o = done[rd_ptr]; core_rdata_o/core_rflags_o come from entry[rd_ptr].
  - On core_rvalid_o && core_rready_i: done[rd_ptr] <= 0, rd_ptr++.
  - No bypass: a response written in cycle N is visible on core_rvalid_o in cycle N+1.
- count: +1 on accept, -1 on retire; both in one cycle leaves it unchanged. Range 0..DEPTH.
- Boundaries:
  - Full (count=DEPTH): core_ready_o=0, even with apu_gnt_i=1.
  - Empty: core_rvalid_o=0.
  - Pointer wrap DEPTH-1 -> 0 is seamless.
  - Response to the head slot while the core stalls: core_rvalid_o is held with stable data.
  - Response and retire of different slots in the same cycle: both take effect.
- Responses: responses arriving while rst=1 are discarded. Reset mid-operation requires the responder to be reset/flushed concurrently.

Optional Feature:
- Macro APU_MASTER_TAG_CHECK_EN.
- Defined: a response is dropped, and tag_err_o sets sticky until rst, when any of these hold:
  - upper rID bits are nonzero;
  - the slot is not allocated (not between rd_ptr and wr_ptr with count);
  - the slot's done bit is already 1.
- Not defined: no check; the response writes unconditionally; tag_err_o tied 0.

Test Plan:
- Single op: op=0x01, operands {0x3F800000,0x40000000}, responder gnt immediately, replies 3 cycles later with rID=0, data 0x40400000, flags 0 -> apu_req_o cycle N+1, apu_ID_o=0; core_rvalid_o one cycle after rvalid with 0x40400000; busy_o falls after retire.
- Grant stall: apu_gnt_i=0 for 5 cycles -> apu_req_o, apu_ID_o, payload stable; core_ready_o=0 throughout.
- Out-of-order: issue 4 ops (IDs 0..3), respond in order 2,0,3,1 with data 0xA2,0xA0,0xA3,0xA1 -> core sees 0xA0,0xA1,0xA2,0xA3 in order; 5th request stalls until first retire.
- Wrap and back-pressure: 10 ops with core_rready_i toggling every other cycle -> IDs go 0,1,2,3,0,1…; no loss or duplication; count never exceeds 4.
- Simultaneous accept/retire at count=DEPTH-1 -> count unchanged, ready stays 1.
- With APU_MASTER_TAG_CHECK_EN: response rID=2 while only slot 0 is allocated -> dropped, tag_err_o=1 until rst, slot 0 still completes correctly.

Source files
------------

// File: rtl/apu_master_rob.sv
// APU initiator with reorder buffer: tags ops with a ROB slot, collects out-of-order responses, retires results in issue order.
// Latency: accept in cycle N drives apu_req_o in N+1; a response written in cycle N shows on core_rvalid_o in N+1.
// Backpressure: core_ready_o drops when the ROB is full or a request is pending without grant; APU responses are never stalled.
// Optional build macro APU_MASTER_TAG_CHECK_EN drops bad-tag responses and raises a sticky tag_err_o.
module apu_master_rob #(
  parameter int ID_WIDTH        = 9,
  parameter int NB_ARGS         = 2,
  parameter int OPCODE_WIDTH    = 6,
  parameter int DATA_WIDTH      = 32,
  parameter int FLAGS_IN_WIDTH  = 15,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int DEPTH           = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            core_valid_i,
  output logic                            core_ready_o,
  input  logic [NB_ARGS*DATA_WIDTH-1:0]   core_operands_i,
  input  logic [OPCODE_WIDTH-1:0]         core_op_i,
  input  logic [FLAGS_IN_WIDTH-1:0]       core_flags_i,
  output logic                            core_rvalid_o,
  input  logic                            core_rready_i,
  output logic [DATA_WIDTH-1:0]           core_rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0]      core_rflags_o,
  output logic                            apu_req_o,
  input  logic                            apu_gnt_i,
  output logic [ID_WIDTH-1:0]             apu_ID_o,
  output logic [NB_ARGS*DATA_WIDTH-1:0]   apu_operands_o,
  output logic [OPCODE_WIDTH-1:0]         apu_op_o,
  output logic [FLAGS_IN_WIDTH-1:0]       apu_flags_o,
  output logic                            apu_rready_o,
  input  logic                            apu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]           apu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0]      apu_rflags_i,
  input  logic [ID_WIDTH-1:0]             apu_rID_i,
  output logic                            tag_err_o,
  output logic                            busy_o
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] L_DEPTH = (PW+1)'(DEPTH);
  localparam logic [PW:0] L_ONE   = (PW+1)'(1);

  // request register
  logic                          r_pending;
  logic [ID_WIDTH-1:0]           r_id;
  logic [NB_ARGS*DATA_WIDTH-1:0] r_operands;
  logic [OPCODE_WIDTH-1:0]       r_op;
  logic [FLAGS_IN_WIDTH-1:0]     r_flags;

  // reorder buffer
  logic [PW-1:0]                 r_wr_ptr;
  logic [PW-1:0]                 r_rd_ptr;
  logic [PW:0]                   r_count;
  logic [DEPTH-1:0]              r_done;
  logic [DATA_WIDTH-1:0]         r_data  [DEPTH];
  logic [FLAGS_OUT_WIDTH-1:0]    r_rflags[DEPTH];

  logic                          w_accept;
  logic                          w_retire;
  logic                          w_resp_wr;
  logic [PW-1:0]                 w_slot;

  assign core_ready_o   = (r_count < L_DEPTH) && (!r_pending || apu_gnt_i);
  assign w_accept       = core_valid_i && core_ready_o;
  assign core_rvalid_o  = r_done[r_rd_ptr];
  assign w_retire       = core_rvalid_o && core_rready_i;
  assign core_rdata_o   = r_data[r_rd_ptr];
  assign core_rflags_o  = r_rflags[r_rd_ptr];
  assign w_slot         = apu_rID_i[PW-1:0];

  assign apu_req_o      = r_pending;
  assign apu_ID_o       = r_id;
  assign apu_operands_o = r_operands;
  assign apu_op_o       = r_op;
  assign apu_flags_o    = r_flags;
  // every issued op already owns a ROB slot, so responses can always land
  assign apu_rready_o   = 1'b1;
  assign busy_o         = (r_count != '0) || r_pending;

`ifdef APU_MASTER_TAG_CHECK_EN
  logic          w_upper_nz;
  logic [PW-1:0] w_offset;
  logic          w_alloc;
  logic          w_tag_bad;
  logic          r_tag_err;

  // slot is live when its distance from the head is below the occupancy
  assign w_upper_nz = (apu_rID_i >> PW) != '0;
  assign w_offset   = w_slot - r_rd_ptr;
  assign w_alloc    = {1'b0, w_offset} < r_count;
  assign w_tag_bad  = w_upper_nz || !w_alloc || r_done[w_slot];
  assign w_resp_wr  = apu_rvalid_i && !w_tag_bad;
  assign tag_err_o  = r_tag_err;

  // sticky error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)                            r_tag_err <= 1'b0;
    else if (apu_rvalid_i && w_tag_bad) r_tag_err <= 1'b1;
  end
`else
  logic w_unused_rid;
  assign w_unused_rid = ^apu_rID_i;
  assign w_resp_wr    = apu_rvalid_i;
  assign tag_err_o    = 1'b0;
`endif

  // hold the request until granted; a same-cycle accept replaces it for back-to-back issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_id       <= '0;
      r_operands <= '0;
      r_op       <= '0;
      r_flags    <= '0;
    end else if (w_accept) begin
      r_pending  <= 1'b1;
      r_id       <= ID_WIDTH'(r_wr_ptr);
      r_operands <= core_operands_i;
      r_op       <= core_op_i;
      r_flags    <= core_flags_i;
    end else if (apu_gnt_i) begin
      r_pending  <= 1'b0;
    end
  end

  // allocation/retire pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_retire) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + L_ONE;
        2'b01:   r_count <= r_count - L_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // ROB entries: responses fill by tag, the head clears on retire
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i]   <= '0;
        r_rflags[i] <= '0;
      end
    end else begin
      if (w_retire) r_done[r_rd_ptr] <= 1'b0;
      if (w_resp_wr) begin
        r_done[w_slot]   <= 1'b1;
        r_data[w_slot]   <= apu_rdata_i;
        r_rflags[w_slot] <= apu_rflags_i;
      end
    end
  end

endmodule

// File: tb/tb_apu_master_rob.sv
// Bench for apu_master_rob: directed stimulus, queue-based in-order model, per-cycle compare.
// Model keeps an issue-ordered list of outstanding ops; responses mark entries by tag.
// Literal checks pin latency, stall, ordering, wrap and boundary behaviour.
module tb_apu_master_rob;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_valid_i = 1'b0;
  logic        core_ready_o;
  logic [63:0] core_operands_i = '0;
  logic [5:0]  core_op_i = '0;
  logic [14:0] core_flags_i = '0;
  logic        core_rvalid_o;
  logic        core_rready_i = 1'b1;
  logic [31:0] core_rdata_o;
  logic [4:0]  core_rflags_o;
  logic        apu_req_o;
  logic        apu_gnt_i = 1'b0;
  logic [8:0]  apu_ID_o;
  logic [63:0] apu_operands_o;
  logic [5:0]  apu_op_o;
  logic [14:0] apu_flags_o;
  logic        apu_rready_o;
  logic        apu_rvalid_i = 1'b0;
  logic [31:0] apu_rdata_i = '0;
  logic [4:0]  apu_rflags_i = '0;
  logic [8:0]  apu_rID_i = '0;
  logic        tag_err_o;
  logic        busy_o;

  apu_master_rob dut (
    .clk(clk), .rst(rst),
    .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
    .core_operands_i(core_operands_i), .core_op_i(core_op_i), .core_flags_i(core_flags_i),
    .core_rvalid_o(core_rvalid_o), .core_rready_i(core_rready_i),
    .core_rdata_o(core_rdata_o), .core_rflags_o(core_rflags_o),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_ID_o(apu_ID_o),
    .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
    .apu_rready_o(apu_rready_o), .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i),
    .apu_rflags_i(apu_rflags_i), .apu_rID_i(apu_rID_i),
    .tag_err_o(tag_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int          tag;
    bit          done;
    logic [31:0] data;
    logic [4:0]  fl;
  } ent_t;

  ent_t        mq[$];
  ent_t        e_tmp;
  bit          m_pend;
  logic [8:0]  m_id;
  logic [63:0] m_ops;
  logic [5:0]  m_op;
  logic [14:0] m_fl;
  int          m_tagn;
  int          m_nacc = 0;
  bit          m_terr;
  bit          rst_seen;
  bit          m_acc, m_ret;
  int          m_idx;
  logic [31:0] ret_log[$];

  function automatic bit exp_ready();
    return (mq.size() < DEPTH) && (!m_pend || apu_gnt_i);
  endfunction

  function automatic bit exp_rvalid();
    return (mq.size() > 0) && mq[0].done;
  endfunction

  always @(posedge clk) begin
    rst_seen = rst;
    if (rst) begin
      mq.delete();
      m_pend = 0; m_tagn = 0; m_terr = 0;
    end else begin
      m_acc = core_valid_i && exp_ready();
      m_ret = exp_rvalid() && core_rready_i;
      if (apu_rvalid_i) begin
        m_idx = -1;
        for (int i = 0; i < mq.size(); i++)
          if (m_idx < 0 && mq[i].tag == int'(apu_rID_i[1:0])) m_idx = i;
`ifdef APU_MASTER_TAG_CHECK_EN
        if ((apu_rID_i >> 2) != 0 || m_idx < 0 || mq[m_idx].done) m_terr = 1;
        else begin
`else
        if (m_idx >= 0) begin
`endif
          e_tmp = mq[m_idx];
          e_tmp.done = 1; e_tmp.data = apu_rdata_i; e_tmp.fl = apu_rflags_i;
          mq[m_idx] = e_tmp;
        end
      end
      if (m_ret) begin
        ret_log.push_back(mq[0].data);
        void'(mq.pop_front());
      end
      if (m_acc) begin
        m_pend = 1;
        m_id   = 9'(m_tagn % DEPTH);
        m_ops  = core_operands_i; m_op = core_op_i; m_fl = core_flags_i;
        e_tmp.tag = m_tagn % DEPTH; e_tmp.done = 0; e_tmp.data = '0; e_tmp.fl = '0;
        mq.push_back(e_tmp);
        m_tagn++; m_nacc++;
      end else if (apu_gnt_i) begin
        m_pend = 0;
      end
    end
  end

  // compare DUT against the model every cycle
  always @(negedge clk) begin
    if (rst_seen) begin
      chk("rst_req", apu_req_o, 0);       chk("rst_rvalid", core_rvalid_o, 0);
      chk("rst_busy", busy_o, 0);         chk("rst_tagerr", tag_err_o, 0);
      chk("rst_id", apu_ID_o, 0);         chk("rst_ops", apu_operands_o, 0);
      chk("rst_op", apu_op_o, 0);         chk("rst_flags", apu_flags_o, 0);
      chk("rst_rdata", core_rdata_o, 0);  chk("rst_rflags", core_rflags_o, 0);
      chk("rst_ready", core_ready_o, 1);  chk("rst_rready", apu_rready_o, 1);
    end else begin
      chk("ready", core_ready_o, exp_ready());
      chk("req", apu_req_o, m_pend);
      chk("rvalid", core_rvalid_o, exp_rvalid());
      chk("busy", busy_o, (mq.size() > 0) || m_pend);
      chk("apu_rready", apu_rready_o, 1);
      chk("tag_err", tag_err_o, m_terr);
      if (m_pend) begin
        chk("id", apu_ID_o, m_id);
        chk("ops", apu_operands_o, m_ops);
        chk("op", apu_op_o, m_op);
        chk("flags", apu_flags_o, m_fl);
      end
      if (exp_rvalid()) begin
        chk("rdata", core_rdata_o, mq[0].data);
        chk("rflags", core_rflags_o, mq[0].fl);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit          resp_en = 0;
  bit          tog_en  = 0;
  logic [40:0] rq[$];
  logic [40:0] r_tmp;
  logic [8:0]  id_log[$];

  task automatic step();
    if (resp_en && apu_req_o && apu_gnt_i) rq.push_back({apu_ID_o, apu_operands_o[31:0]});
    @(posedge clk); #1;
    if (resp_en) begin
      if (rq.size() > 0) begin
        r_tmp = rq.pop_front();
        apu_rvalid_i = 1; apu_rID_i = r_tmp[40:32];
        apu_rdata_i  = r_tmp[31:0] ^ 32'h5A5A0000;
        apu_rflags_i = r_tmp[36:32];
        id_log.push_back(r_tmp[40:32]);
      end else apu_rvalid_i = 0;
    end
    if (tog_en) core_rready_i = ~core_rready_i;
  endtask

  task automatic issue(input logic [63:0] ops, input logic [5:0] op);
    int n0, n;
    core_operands_i = ops; core_op_i = op; core_flags_i = {9'h0, op};
    core_valid_i = 1;
    n0 = m_nacc; n = 0;
    while (m_nacc == n0 && n < 50) begin step(); n++; end
    core_valid_i = 0;
    chk("accept_timeout", n < 50, 1);
  endtask

  task automatic respond(input logic [8:0] id, input logic [31:0] d);
    apu_rvalid_i = 1; apu_rID_i = id; apu_rdata_i = d; apu_rflags_i = d[4:0];
    step();
    apu_rvalid_i = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((mq.size() > 0 || m_pend) && n < 200) begin step(); n++; end
    chk("idle_timeout", n < 200, 1);
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0; step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int base, n0, n;
    logic [31:0] ta[4], td[4];
    do_reset();

    // single op
    apu_gnt_i = 1; core_rready_i = 1;
    issue({32'h40000000, 32'h3F800000}, 6'h01);
    chk("t1_req", apu_req_o, 1);
    chk("t1_id", apu_ID_o, 0);
    chk("t1_ops", apu_operands_o, 64'h40000000_3F800000);
    step(); step();
    base = ret_log.size();
    respond(9'd0, 32'h40400000);
    chk("t1_rvalid", core_rvalid_o, 1);
    chk("t1_rdata", core_rdata_o, 32'h40400000);
    chk("t1_busy_before", busy_o, 1);
    step();
    chk("t1_busy_after", busy_o, 0);
    chk("t1_log", ret_log[base], 32'h40400000);

    // grant stall
    apu_gnt_i = 0;
    issue(64'h11112222_33334444, 6'h02);
    core_valid_i = 1; core_op_i = 6'h03; core_operands_i = 64'h55556666_77778888;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_req", apu_req_o, 1);
      chk("t2_id", apu_ID_o, 1);
      chk("t2_op", apu_op_o, 6'h02);
      chk("t2_ops", apu_operands_o, 64'h11112222_33334444);
      chk("t2_ready", core_ready_o, 0);
    end
    apu_gnt_i = 1;
    issue(64'h55556666_77778888, 6'h03);
    chk("t2_b2b_id", apu_ID_o, 2);
    chk("t2_b2b_op", apu_op_o, 6'h03);
    step();
    chk("t2_req_drop", apu_req_o, 0);
    base = ret_log.size();
    respond(9'd2, 32'h000000B2);
    respond(9'd1, 32'h000000B1);
    wait_idle();
    chk("t2_log0", ret_log[base], 32'hB1);
    chk("t2_log1", ret_log[base+1], 32'hB2);

    // out-of-order completion, in-order retire
    do_reset();
    apu_gnt_i = 1; core_rready_i = 1;
    for (int i = 0; i < 4; i++) issue(64'(32'h100 + i), 6'(6'h10 + i));
    chk("t3_last_id", apu_ID_o, 3);
    core_valid_i = 1; core_op_i = 6'h14; core_operands_i = 64'h104; core_flags_i = 15'h14;
    #1 chk("t3_full_ready", core_ready_o, 0);
    base = ret_log.size();
    n0 = m_nacc;
    ta[0] = 2; ta[1] = 0; ta[2] = 3; ta[3] = 1;
    td[0] = 32'hA2; td[1] = 32'hA0; td[2] = 32'hA3; td[3] = 32'hA1;
    for (int j = 0; j < 4; j++) begin
      respond(9'(ta[j]), td[j]);
      if (j < 2) chk("t3_stall", core_ready_o, 0);
    end
    n = 0;
    while (m_nacc == n0 && n < 20) begin step(); n++; end
    chk("t3_fifth_timeout", n < 20, 1);
    core_valid_i = 0;
    step();
    respond(9'd0, 32'hA4);
    wait_idle();
    for (int j = 0; j < 5; j++) chk("t3_order", ret_log[base+j], 64'(32'hA0 + j));

    // wrap with toggling core back-pressure
    do_reset();
    apu_gnt_i = 1; resp_en = 1; tog_en = 1;
    id_log.delete();
    base = ret_log.size();
    for (int k = 0; k < 10; k++) issue(64'(32'h200 + k), 6'h20);
    wait_idle();
    resp_en = 0; tog_en = 0; apu_rvalid_i = 0; core_rready_i = 1;
    chk("t4_nresp", id_log.size(), 10);
    chk("t4_nret", ret_log.size() - base, 10);
    for (int k = 0; k < 10; k++) begin
      if (k < id_log.size()) chk("t4_id", id_log[k], 64'(k % 4));
      if (base + k < ret_log.size()) chk("t4_data", ret_log[base+k], 64'((32'h200 + k) ^ 32'h5A5A0000));
    end

    // simultaneous accept and retire at DEPTH-1
    do_reset();
    apu_gnt_i = 1; core_rready_i = 0;
    for (int i = 0; i < 3; i++) issue(64'(32'h300 + i), 6'h30);
    step();
    respond(9'd0, 32'hD0);
    core_valid_i = 1; core_op_i = 6'h31; core_operands_i = 64'h303; core_rready_i = 1;
    #1;
    chk("t5_ready_pre", core_ready_o, 1);
    chk("t5_rvalid_pre", core_rvalid_o, 1);
    step();
    core_valid_i = 0; core_rready_i = 0;
    #1;
    chk("t5_ready_post", core_ready_o, 1);
    chk("t5_rvalid_post", core_rvalid_o, 0);
    issue(64'h304, 6'h32);
    chk("t5_full", core_ready_o, 0);
    step();
    core_rready_i = 1;
    respond(9'd1, 32'hD1); respond(9'd2, 32'hD2);
    respond(9'd3, 32'hD3); respond(9'd0, 32'hD4);
    wait_idle();
    chk("t5_last", ret_log[ret_log.size()-1], 32'hD4);

`ifdef APU_MASTER_TAG_CHECK_EN
    // unallocated tag is dropped and flagged
    do_reset();
    apu_gnt_i = 1; core_rready_i = 1;
    issue(64'h400, 6'h01);
    step();
    respond(9'd2, 32'hE2);
    chk("t6_err", tag_err_o, 1);
    chk("t6_no_rvalid", core_rvalid_o, 0);
    respond(9'd0, 32'hC0);
    chk("t6_rvalid", core_rvalid_o, 1);
    chk("t6_rdata", core_rdata_o, 32'hC0);
    wait_idle();
    chk("t6_sticky", tag_err_o, 1);
    do_reset();
    chk("t6_cleared", tag_err_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
